adder_sum_collector: RTL and testbench

//  Downstream consumer of the 8-bit combinational operand adder. Captures each
//  (a, b, sum) beat over a valid/ready handshake and recovers the carry lost by the
//  8-bit truncation. Checks the sum against its operands and accumulates a running

---
 rtl/adder_sum_collector.sv | 144 ++++++++++++++
 tb/tb_adder_sum_collector.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/adder_sum_collector.sv
// rtl/adder_sum_collector.sv - collects adder beats, recovers carry, emits byte frame
module adder_sum_collector #(
  parameter int ACC_W = 16,
  parameter int SAT   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic [7:0] sum_in,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       ovf,
  output logic       mismatch,
  output logic       busy
);

  localparam int NB    = ACC_W / 8 + 1;
  localparam int IDX_W = $clog2(NB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  typedef enum logic {S_ACCUM = 1'b0, S_EMIT = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [ACC_W-1:0]   r_acc;
  logic [7:0]         r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_ovf;
  logic               r_mismatch;

  logic               w_accept;
  logic               w_xfer;
  logic               w_last_xfer;
  logic               w_carry;
  logic [7:0]         w_ref_sum;
  logic [ACC_W:0]     w_sum;
  logic [ACC_W-1:0]   w_acc_next;
  logic [7:0]         w_byte;

  assign w_accept    = in_valid & in_ready;
  assign w_xfer      = out_valid & out_ready;
  assign w_last_xfer = w_xfer & (r_idx == LAST_IDX);

  // The adder drops its carry; a truncated sum below operand A means it wrapped.
  assign w_carry   = (sum_in < a_in);
  assign w_ref_sum = a_in + b_in;
  assign w_sum     = {1'b0, r_acc} + {{(ACC_W-8){1'b0}}, w_carry, sum_in};

  // Overflow handling: clamp to all-ones or keep the wrapped low bits.
  always_comb begin
    w_acc_next = w_sum[ACC_W-1:0];
    if (w_sum[ACC_W] && (SAT != 0)) begin
      w_acc_next = '1;
    end
  end

  // Frame byte select: accumulator bytes LSB first, then the beat count.
  always_comb begin
    w_byte = r_cnt;
    for (int k = 0; k < NB - 1; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_byte = r_acc[k*8 +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: flush starts a frame; the last byte transfer ends it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_ACCUM: if (flush)       w_state_next = S_EMIT;
      S_EMIT:  if (w_last_xfer) w_state_next = S_ACCUM;
      default:                  w_state_next = S_ACCUM;
    endcase
  end

  // Outputs decoded from state; frame contents stay frozen since no beat lands in EMIT.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    if (r_state == S_EMIT) begin
      in_ready  = 1'b0;
      out_valid = 1'b1;
      busy      = 1'b1;
      out_data  = w_byte;
      out_last  = (r_idx == LAST_IDX);
    end
  end

  // Accumulate beats, advance the frame index, and clear everything at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_cnt      <= 8'h00;
      r_idx      <= '0;
      r_ovf      <= 1'b0;
      r_mismatch <= 1'b0;
    end else if (w_last_xfer) begin
      r_acc      <= '0;
      r_cnt      <= 8'h00;
      r_idx      <= '0;
      r_ovf      <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_accept) begin
        r_acc <= w_acc_next;
        if (w_sum[ACC_W]) begin
          r_ovf <= 1'b1;
        end
        if (sum_in != w_ref_sum) begin
          r_mismatch <= 1'b1;
        end
        if (r_cnt != 8'hFF) begin
          r_cnt <= r_cnt + 8'h01;
        end
      end
    end
  end

  assign ovf      = r_ovf;
  assign mismatch = r_mismatch;

endmodule

// File: tb/tb_adder_sum_collector.sv
// tb/tb_adder_sum_collector.sv - directed bench for adder_sum_collector
module tb_adder_sum_collector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a_in = 8'h00;
  logic [7:0] b_in = 8'h00;
  logic [7:0] sum_in = 8'h00;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, out_last, ovf, mismatch, busy;
  logic [7:0] out_data;

  logic       in_valid0 = 1'b0;
  logic       flush0 = 1'b0;
  logic       out_ready0 = 1'b0;
  logic       in_ready0, out_valid0, out_last0, ovf0, mismatch0, busy0;
  logic [7:0] out_data0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  adder_sum_collector #(.ACC_W(16), .SAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .sum_in(sum_in),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .ovf(ovf), .mismatch(mismatch), .busy(busy)
  );

  adder_sum_collector #(.ACC_W(16), .SAT(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .sum_in(sum_in),
    .in_valid(in_valid0), .in_ready(in_ready0), .flush(flush0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_last(out_last0), .ovf(ovf0), .mismatch(mismatch0), .busy(busy0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s);
    a_in = a; b_in = b; sum_in = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic recv_byte(input bit sel, input logic [7:0] exp_d, input bit exp_l, input string tag);
    int t = 0;
    while (((sel ? out_valid0 : out_valid) !== 1'b1) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, ".valid"}, sel ? out_valid0 : out_valid, 1);
    chk({tag, ".data"},  sel ? out_data0  : out_data,  exp_d);
    chk({tag, ".last"},  sel ? out_last0  : out_last,  exp_l);
    @(negedge clk);
  endtask

  task automatic recv3(input bit sel, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input string tag);
    recv_byte(sel, d0, 1'b0, {tag, ".b0"});
    recv_byte(sel, d1, 1'b0, {tag, ".b1"});
    recv_byte(sel, d2, 1'b1, {tag, ".b2"});
  endtask

  initial begin
    @(negedge clk);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_last", out_last, 0);
    chk("rst.busy", busy, 0);
    chk("rst.out_data", out_data, 0);
    chk("rst.ovf", ovf, 0);
    chk("rst.mismatch", mismatch, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Flush straight out of reset: empty frame.
    do_flush();
    chk("empty.busy", busy, 1);
    recv3(0, 8'h00, 8'h00, 8'h01 - 8'h01, "empty");
    chk("empty.done_valid", out_valid, 0);
    chk("empty.done_busy", busy, 0);

    // Two beats, one with carry.
    beat(8'd200, 8'd100, 8'd44);
    beat(8'd10, 8'd5, 8'd15);
    do_flush();
    chk("t1.ovf", ovf, 0);
    chk("t1.mismatch", mismatch, 0);
    recv3(0, 8'h3B, 8'h01, 8'h02, "t1");

    // Mismatching beat is still accumulated; flag sticks until frame end.
    beat(8'd1, 8'd1, 8'd3);
    do_flush();
    chk("t2.mm_b0", mismatch, 1);
    recv_byte(0, 8'h03, 1'b0, "t2.b0");
    recv_byte(0, 8'h00, 1'b0, "t2.b1");
    chk("t2.mm_b2", mismatch, 1);
    recv_byte(0, 8'h01, 1'b1, "t2.b2");
    chk("t2.mm_clr", mismatch, 0);

    // Flush coincident with a beat, plus stray flush pulses during EMIT.
    a_in = 8'd3; b_in = 8'd4; sum_in = 8'd7; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t5.in_ready", in_ready, 0);
    recv_byte(0, 8'h07, 1'b0, "t5.b0");
    flush = 1'b0;
    recv_byte(0, 8'h00, 1'b0, "t5.b1");
    flush = 1'b1;
    recv_byte(0, 8'h01, 1'b1, "t5.b2");
    flush = 1'b0;
    chk("t5.no2nd_a", out_valid, 0);
    @(negedge clk);
    chk("t5.no2nd_b", out_valid, 0);

    // Backpressure on byte 1 with an upstream beat held pending.
    beat(8'd2, 8'd3, 8'd5);
    do_flush();
    recv_byte(0, 8'h05, 1'b0, "t4.b0");
    out_ready = 1'b0;
    a_in = 8'd1; b_in = 8'd2; sum_in = 8'd3; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4.hold_data", out_data, 8'h00);
      chk("t4.hold_last", out_last, 0);
      chk("t4.hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    recv_byte(0, 8'h00, 1'b0, "t4.b1");
    recv_byte(0, 8'h01, 1'b1, "t4.b2");
    chk("t4.in_ready_after", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    do_flush();
    recv3(0, 8'h03, 8'h00, 8'h01, "t4.held");

    // Overflow: saturating instance takes 300 beats, wrapping instance 129.
    a_in = 8'd255; b_in = 8'd255; sum_in = 8'hFE;
    for (int i = 1; i <= 300; i++) begin
      in_valid = 1'b1;
      in_valid0 = (i <= 129);
      @(negedge clk);
      if (i == 128) chk("t3.ovf_128", ovf, 0);
      if (i == 129) begin
        chk("t3.ovf_129", ovf, 1);
        chk("t3.ovf0_129", ovf0, 1);
      end
    end
    in_valid = 1'b0;
    in_valid0 = 1'b0;
    flush = 1'b1; flush0 = 1'b1;
    @(negedge clk);
    flush = 1'b0; flush0 = 1'b0;
    chk("t3.ovf_emit", ovf, 1);
    recv3(0, 8'hFF, 8'hFF, 8'hFF, "t3.sat");
    chk("t3.ovf_clr", ovf, 0);
    out_ready0 = 1'b1;
    recv3(1, 8'hFE, 8'h00, 8'h81, "t3.wrap");
    chk("t3.ovf0_clr", ovf0, 0);

    // Asynchronous reset while byte 1 is pending.
    beat(8'd1, 8'd2, 8'd3);
    do_flush();
    recv_byte(0, 8'h03, 1'b0, "t6.b0");
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6.async_valid", out_valid, 0);
    chk("t6.async_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6.in_ready", in_ready, 1);
    out_ready = 1'b1;
    do_flush();
    recv3(0, 8'h00, 8'h00, 8'h00, "t6.after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
